// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Instruction fetch stage of the 16-bit ThinPad pipeline. Owns the program
// counter and drives a request/ready read port toward instruction memory.
// Fetching pauses while the data stage owns the shared memory. One returned
// instruction is buffered while decode is stalled. The IF/ID register is
// redirected on branches and jumps that are resolved in ID.
//
// Ports:
//   clk              rising-edge clock
//   rst              asynchronous, active-low reset
//   stall_i          decode hazard stall; IF/ID holds its contents
//   branch_i         taken branch/jump resolved in ID this cycle
//   branch_target_i  redirect PC, valid together with branch_i
//   mem_conflict_i   data stage owns the memory; no fetch request this cycle
//   imem_addr_o      fetch address (always the current PC)
//   imem_req_o       fetch request
//   imem_ready_i     read data valid (zero-wait or later)
//   imem_data_i      instruction word, taken when req && ready
//   ifid_valid_o     IF/ID holds a real instruction
//   ifid_inst_o      IF/ID instruction
//   ifid_pc_o        address of the IF/ID instruction + 1
// -----------------------------------------------------------------------------
module instruction_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_INST = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_i,
    input  logic [15:0] branch_target_i,
    input  logic        mem_conflict_i,
    output logic [15:0] imem_addr_o,
    output logic        imem_req_o,
    input  logic        imem_ready_i,
    input  logic [15:0] imem_data_i,
    output logic        ifid_valid_o,
    output logic [15:0] ifid_inst_o,
    output logic [15:0] ifid_pc_o
);

    // START: the single idle cycle after reset release.
    // FETCH: requesting instructions.
    // HOLD:  one instruction buffered, waiting for the stall to clear.
    typedef enum logic [1:0] {
        START = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    typedef struct packed {
        logic        valid;
        logic [15:0] inst;
        logic [15:0] pc;
    } ifid_t;

    typedef struct packed {
        logic [15:0] inst;
        logic [15:0] pc;
    } entry_t;

    localparam ifid_t BUBBLE = '{valid: 1'b0, inst: NOP_INST, pc: 16'h0000};

    state_t      state, state_next;
    logic [15:0] pc, pc_next;
    entry_t      hold_buf, hold_buf_next;
    ifid_t       ifid, ifid_next;

    logic        accept;
    logic [15:0] pc_inc;

    // The request depends only on registered state and live inputs, so an
    // asynchronous reset forcing state to START drops it at once.
    assign imem_req_o  = (state == FETCH) && !mem_conflict_i && !branch_i;
    assign imem_addr_o = pc;
    assign accept      = imem_req_o && imem_ready_i;
    assign pc_inc      = pc + 16'd1;   // natural 16-bit wrap FFFF -> 0000

    assign ifid_valid_o = ifid.valid;
    assign ifid_inst_o  = ifid.inst;
    assign ifid_pc_o    = ifid.pc;

    always_comb begin
        // NOTE: every signal written here gets a default first so that no
        // path through the case leaves it unassigned and infers a latch.
        state_next    = state;
        pc_next       = pc;
        hold_buf_next = hold_buf;
        ifid_next     = ifid;

        // PC advances on any accepted fetch, independent of the stall; the
        // stall only decides whether the word goes to IF/ID or the buffer.
        if (accept) begin
            pc_next = pc_inc;
        end

        if (branch_i) begin
            // req is forced low during a branch, so nothing can be accepted
            // and any response arriving now is simply dropped.
            pc_next       = branch_target_i;
            hold_buf_next = '0;
            ifid_next     = BUBBLE;
            state_next    = FETCH;
        end else begin
            case (state)
                START: begin
                    state_next = FETCH;
                end
                FETCH: begin
                    if (stall_i) begin
                        if (accept) begin
                            hold_buf_next = '{inst: imem_data_i, pc: pc_inc};
                            state_next    = HOLD;
                        end
                    end else if (accept) begin
                        ifid_next = '{valid: 1'b1, inst: imem_data_i, pc: pc_inc};
                    end else begin
                        ifid_next = BUBBLE;
                    end
                end
                HOLD: begin
                    // Request stays low this cycle; next fetch issues after.
                    if (!stall_i) begin
                        ifid_next  = '{valid: 1'b1, inst: hold_buf.inst, pc: hold_buf.pc};
                        state_next = FETCH;
                    end
                end
                default: begin
                    state_next = START;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= START;
            pc       <= RESET_PC;
            hold_buf <= '0;
            ifid     <= BUBBLE;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            hold_buf <= hold_buf_next;
            ifid     <= ifid_next;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
//
// Randomized self-checking bench for instruction_fetch. Memory returns
// addr ^ 16'h0800 whenever ready is high. The reference model tracks the
// fetch stage as "started" plus a queue of buffered instructions and
// predicts the request, the address and the IF/ID contents every cycle.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam logic [15:0] NOP_INST = 16'h0800;
    localparam int          N_CYCLES = 2000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch;
    logic [15:0] target;
    logic        conflict;
    logic [15:0] addr;
    logic        req;
    logic        ready;
    logic [15:0] data;
    logic        valid_o;
    logic [15:0] inst_o;
    logic [15:0] pc_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign data = addr ^ 16'h0800;

    instruction_fetch #(
        .RESET_PC(RESET_PC),
        .NOP_INST(NOP_INST)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall_i        (stall),
        .branch_i       (branch),
        .branch_target_i(target),
        .mem_conflict_i (conflict),
        .imem_addr_o    (addr),
        .imem_req_o     (req),
        .imem_ready_i   (ready),
        .imem_data_i    (data),
        .ifid_valid_o   (valid_o),
        .ifid_inst_o    (inst_o),
        .ifid_pc_o      (pc_o)
    );

    // ---------------- reference model ----------------
    typedef struct {
        logic [15:0] inst;
        logic [15:0] pc;
    } entry_t;

    bit          m_started;
    logic [15:0] m_pc;
    entry_t      m_buf[$];
    logic        m_valid;
    logic [15:0] m_inst;
    logic [15:0] m_ifpc;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'h0800;
    endfunction

    task automatic model_bubble();
        m_valid = 1'b0;
        m_inst  = NOP_INST;
        m_ifpc  = 16'h0000;
    endtask

    task automatic model_reset();
        m_started = 1'b0;
        m_pc      = RESET_PC;
        m_buf.delete();
        model_bubble();
    endtask

    function automatic bit model_req();
        return m_started && (m_buf.size() == 0) && !conflict && !branch;
    endfunction

    // Advance the model across one rising edge using the current inputs.
    task automatic model_step();
        bit     acc;
        entry_t e;
        acc = model_req() && ready;
        if (!m_started) begin
            m_started = 1'b1;
            if (branch) begin
                m_pc = target;
                model_bubble();
            end
        end else if (branch) begin
            m_pc = target;
            m_buf.delete();
            model_bubble();
        end else begin
            if (acc) begin
                e.inst = mem_word(m_pc);
                e.pc   = m_pc + 16'd1;
                m_pc   = e.pc;
            end
            if (stall) begin
                if (acc) m_buf.push_back(e);
            end else if (m_buf.size() != 0) begin
                e       = m_buf.pop_front();
                m_valid = 1'b1;
                m_inst  = e.inst;
                m_ifpc  = e.pc;
            end else if (acc) begin
                m_valid = 1'b1;
                m_inst  = e.inst;
                m_ifpc  = e.pc;
            end else begin
                model_bubble();
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic check_ifid();
        check("ifid_valid", {15'b0, valid_o}, {15'b0, m_valid});
        check("ifid_inst", inst_o, m_inst);
        check("ifid_pc", pc_o, m_ifpc);
    endtask

    // Stimulus profile by phase: clean zero-wait stream, then random wait
    // states, then everything mixed including branches near the wrap point.
    task automatic drive(input int cyc);
        int phase;
        int sel;
        phase = cyc / 500;
        stall    = 1'b0;
        conflict = 1'b0;
        branch   = 1'b0;
        target   = 16'h0000;
        case (phase)
            0: ready = 1'b1;
            1: ready = 1'($urandom_range(0, 1));
            default: begin
                ready    = ($urandom_range(0, 9) < 7);
                stall    = ($urandom_range(0, 3) == 0);
                conflict = ($urandom_range(0, 6) == 0);
                branch   = ($urandom_range(0, 11) == 0);
                sel      = int'($urandom_range(0, 3));
                case (sel)
                    0: target = 16'h0024;
                    1: target = 16'hFFFE;
                    2: target = 16'hFFFF;
                    default: target = 16'($urandom);
                endcase
            end
        endcase
    endtask

    initial begin
        rst      = 1'b0;
        stall    = 1'b0;
        branch   = 1'b0;
        target   = 16'h0000;
        conflict = 1'b0;
        ready    = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check("reset_req", {15'b0, req}, 16'h0000);
        check("reset_addr", addr, RESET_PC);
        check_ifid();
        @(posedge clk);
        #3 rst = 1'b1;

        for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
            @(negedge clk);
            check_ifid();
            drive(cyc);
            #1;
            check("req", {15'b0, req}, {15'b0, model_req()});
            check("addr", addr, m_pc);
            if (cyc == 800 || cyc == 1700) begin
                // Asynchronous reset in the middle of a cycle, likely with a
                // fetch in flight: request must drop without a clock edge.
                #1 rst = 1'b0;
                #1;
                model_reset();
                check("async_req", {15'b0, req}, 16'h0000);
                check("async_addr", addr, m_pc);
                check_ifid();
                @(posedge clk);
                #3 rst = 1'b1;
                continue;
            end
            @(posedge clk);
            model_step();
        end

        @(negedge clk);
        check_ifid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
